ddr3_mem_scheduler: RTL and testbench
=====================================

DDR3_MEM_SCHEDULER -- requirements
Module: ddr3_mem_scheduler

Interface
Parameters:
REQ-001 The block SHALL have parameter T_INIT, default 8: NOP cycles between reset release and ZQC.
REQ-002 The block SHALL have parameter T_RCD, default 2, legal 2..15: cycles from ACT to RD/WR.
REQ-003 The block SHALL have parameter T_RP, default 2, legal 1..15: cycles from PRE to next ACT or REF.
REQ-004 The block SHALL have parameter T_RFC, default 10: cycles from REF to next command.
REQ-005 The block SHALL have parameter T_REFI, default 780: refresh interval in cycles.
Ports:
REQ-006 The block SHALL have port cpu_clk, input, 1 bit: the single clock; the memory CK is driven from it.
REQ-007 The block SHALL have port cpu_reset, input, 1 bit: asynchronous, active-high reset.
REQ-008 The block SHALL have the CPU request ports: req_valid in 1; req_ready out 1; req_write in 1; req_row in 15; req_col in 6; req_wdata in 64 (beat k = bits 16k+15:16k).
REQ-009 The block SHALL have the CPU response ports: rsp_valid out 1; rsp_rdata out 64 (same beat packing); wr_done out 1.
REQ-010 The block SHALL have the memory ports: mem_reset_n out 1; cs_n, ras_n, cas_n, we_n out 1 each; addr out 15 (row); col out 6; wr_data out 16; rd_data in 16.

Function
REQ-011 Commands {cs_n,ras_n,cas_n,we_n} SHALL be: NOP 0111, ACT 0011, RD 0101, WR 0100, PRE 0010, REF 0001, ZQC 0110; NOP in every cycle with no command.
REQ-012 The FSM states SHALL be: INIT_WAIT, INIT_ZQC, IDLE, PRE_ISSUE, RP_WAIT, ACT_ISSUE, RCD_WAIT, CMD_ISSUE, BURST, REF_ISSUE, RFC_WAIT.
REQ-013 The FSM SHALL hold mem_reset_n at 1 from the first cycle after reset release, issue NOP for T_INIT cycles in INIT_WAIT, issue ZQC for one cycle in INIT_ZQC, and then enter IDLE with no row open.
REQ-014 req_ready SHALL be 1 only in IDLE with no refresh pending; a request is accepted when req_valid and req_ready are both 1 in the same cycle, and all request fields are latched then.
REQ-015 The block SHALL track one open row (row-valid flag and 15-bit row register).
REQ-016 Row hit (row open, row equal): CMD_ISSUE SHALL issue RD/WR in the cycle after acceptance.
REQ-017 No row open: the block SHALL issue ACT in the cycle after acceptance, wait T_RCD cycles from ACT, then issue RD/WR.
REQ-018 Row miss (a different row open): the block SHALL issue PRE in the cycle after acceptance, issue ACT T_RP cycles after PRE, and issue RD/WR T_RCD cycles after ACT.
REQ-019 addr SHALL carry the latched row during ACT, CMD_ISSUE and BURST.
REQ-020 A burst SHALL be 4 beats at {col[5:2],beat[1:0]}, beat 0..3, in the 4 cycles after RD/WR (BURST state); col[1:0] of the request is ignored.
REQ-021 Write: in beat k the block SHALL drive col = base+k and wr_data = req_wdata beat k.
REQ-022 Read: in beat k the block SHALL capture rd_data into rsp_rdata beat k.
REQ-023 Only NOP SHALL be issued during BURST; this includes the last beat, in which a command would be misinterpreted by the memory.
REQ-024 Read: rsp_valid SHALL pulse for 1 cycle in the cycle after beat 3, and rsp_rdata SHALL hold its value until the next read completes.
REQ-025 Write: wr_done SHALL pulse for 1 cycle in the cycle after beat 3.
REQ-026 After BURST the FSM SHALL return to IDLE with the row left open (open-page policy).
REQ-027 The refresh counter SHALL count from T_REFI-1 down to 0 continuously outside INIT; at 0 it SHALL set refresh_pending and reload.
REQ-028 When refresh_pending is set in IDLE, the block SHALL issue PRE (only if a row is open) and wait T_RP, then issue REF and wait T_RFC, then clear refresh_pending, close the row, and return to IDLE.
REQ-029 When refresh_pending and req_valid coincide, refresh SHALL win: req_ready is 0 and the request waits.
REQ-030 A refresh that expires mid-operation SHALL stay pending until IDLE; it is never preempted or lost, and a second expiry while pending is merged.
REQ-031 Wait counters SHALL be saturating down-counters loaded on the command cycle, with the transition taken at 0.

Reset
REQ-032 While cpu_reset is 1 (asynchronously, at any point including mid-burst), the block SHALL set: state INIT_WAIT; mem_reset_n 0; command NOP; addr 0; col 0; wr_data 0; req_ready 0; rsp_valid 0; wr_done 0; rsp_rdata 0; row-valid 0; refresh_pending 0; all counters 0. No partial response SHALL follow the reset.

Structure
REQ-033 Package ddr3_mem_pkg SHALL hold the command encoding constants, the scheduler state enum and the default timing constants.
REQ-034 The block SHALL instantiate one sub-module, ddr3_mem_timer (a loadable down-counter with a zero flag), once for the wait timer and once for the refresh interval.

Verification
REQ-035 The bench SHALL cover init: reset release -> 8 NOPs, then ZQC at cycle 9, then req_ready=1 at cycle 10.
REQ-036 The bench SHALL cover a closed-row read of row 0x0123, col 0x08 accepted at cycle 0 -> ACT@1, RD@3, col 8..11 @4..7, rsp_valid@8 with the 4 captured words.
REQ-037 The bench SHALL cover a row-hit write of 0x4444_3333_2222_1111 at col 0x3F -> WR@1, cols 60..63 with data 1111,2222,3333,4444 @2..5, wr_done@6.
REQ-038 The bench SHALL cover a row miss (0x0123 open, request row 0x7FFF) -> PRE@1, ACT@3, RD@5, rsp_valid@10.
REQ-039 The bench SHALL cover refresh_pending set together with req_valid and row open -> req_ready=0, PRE, REF after T_RP, then the request is served as no-row-open after T_RFC.
REQ-040 The bench SHALL cover cpu_reset asserted during read beat 2 -> immediate NOP/mem_reset_n=0, no rsp_valid, and a full init sequence after release.

Source files
------------

// File: rtl/ddr3_mem_pkg.sv
// rtl/ddr3_mem_pkg.sv - DDR3 scheduler command encodings, state enum and default timings
package ddr3_mem_pkg;

    // {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] CMD_NOP = 4'b0111;
    localparam logic [3:0] CMD_ACT = 4'b0011;
    localparam logic [3:0] CMD_RD  = 4'b0101;
    localparam logic [3:0] CMD_WR  = 4'b0100;
    localparam logic [3:0] CMD_PRE = 4'b0010;
    localparam logic [3:0] CMD_REF = 4'b0001;
    localparam logic [3:0] CMD_ZQC = 4'b0110;

    localparam int DEF_T_INIT = 8;
    localparam int DEF_T_RCD  = 2;
    localparam int DEF_T_RP   = 2;
    localparam int DEF_T_RFC  = 10;
    localparam int DEF_T_REFI = 780;

    typedef enum logic [3:0] {
        INIT_WAIT,
        INIT_ZQC,
        IDLE,
        PRE_ISSUE,
        RP_WAIT,
        ACT_ISSUE,
        RCD_WAIT,
        CMD_ISSUE,
        BURST,
        REF_ISSUE,
        RFC_WAIT
    } state_t;

    // A gap of N cycles between two commands is the issue cycle plus N-1
    // wait-state cycles; the wait timer sits one extra cycle at zero, so it
    // is loaded with N-2.
    function automatic logic [15:0] wait_load(input int cycles);
        return (cycles > 2) ? 16'(cycles - 2) : 16'd0;
    endfunction

endpackage

// File: rtl/ddr3_mem_scheduler_if.sv
// rtl/ddr3_mem_scheduler_if.sv - CPU request/response and DDR3 command bus bundle
// master: environment side (CPU requester plus memory read data)
// slave : scheduler side (accepts requests, drives the memory command bus)
// Ports: req_valid/req_ready/req_write/req_row/req_col/req_wdata, rsp_valid/
//        rsp_rdata/wr_done, mem_reset_n, cs_n/ras_n/cas_n/we_n, addr, col,
//        wr_data, rd_data. 64-bit data packs beat k in bits 16k+15:16k.
interface ddr3_mem_scheduler_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [14:0] req_row;
    logic [5:0]  req_col;
    logic [63:0] req_wdata;

    logic        rsp_valid;
    logic [63:0] rsp_rdata;
    logic        wr_done;

    logic        mem_reset_n;
    logic        cs_n;
    logic        ras_n;
    logic        cas_n;
    logic        we_n;
    logic [14:0] addr;
    logic [5:0]  col;
    logic [15:0] wr_data;
    logic [15:0] rd_data;

    modport master (
        output req_valid, req_write, req_row, req_col, req_wdata, rd_data,
        input  req_ready, rsp_valid, rsp_rdata, wr_done,
        input  mem_reset_n, cs_n, ras_n, cas_n, we_n, addr, col, wr_data
    );

    modport slave (
        input  req_valid, req_write, req_row, req_col, req_wdata, rd_data,
        output req_ready, rsp_valid, rsp_rdata, wr_done,
        output mem_reset_n, cs_n, ras_n, cas_n, we_n, addr, col, wr_data
    );

endinterface

// File: rtl/ddr3_mem_timer.sv
// rtl/ddr3_mem_timer.sv - loadable saturating down-counter with zero flag
// Ports: clk, rst (async active-high), load/load_value (load wins), en
//        (decrement, stops at 0), zero (count == 0).
module ddr3_mem_timer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             en,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (en && count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/ddr3_mem_scheduler.sv
// rtl/ddr3_mem_scheduler.sv - single-bank open-page DDR3 command scheduler with refresh
// Ports: cpu_clk (single clock, also memory CK), cpu_reset (async active-high),
//        bus (ddr3_mem_scheduler_if.slave: CPU request/response + DDR3 command bus).
module ddr3_mem_scheduler
    import ddr3_mem_pkg::*;
#(
    parameter int T_INIT = DEF_T_INIT,
    parameter int T_RCD  = DEF_T_RCD,
    parameter int T_RP   = DEF_T_RP,
    parameter int T_RFC  = DEF_T_RFC,
    parameter int T_REFI = DEF_T_REFI
) (
    input  logic                  cpu_clk,
    input  logic                  cpu_reset,
    ddr3_mem_scheduler_if.slave   bus
);

    localparam logic [15:0] INIT_LOAD = 16'(T_INIT - 1);
    localparam logic [15:0] RP_LOAD   = wait_load(T_RP);
    localparam logic [15:0] RCD_LOAD  = wait_load(T_RCD);
    localparam logic [15:0] RFC_LOAD  = wait_load(T_RFC);
    localparam logic [15:0] REFI_LOAD = 16'(T_REFI - 1);

    state_t      state;
    state_t      next_state;

    logic        mem_rst_n_q;
    logic        wr_q;
    logic [14:0] row_q;
    logic [3:0]  col_base_q;
    logic [63:0] wdata_q;
    logic        row_valid;
    logic [14:0] open_row;
    logic        refresh_pending;
    logic        req_busy;
    logic [1:0]  beat;
    logic [47:0] rd_buf;
    logic [63:0] rdata_q;
    logic        rsp_valid_q;
    logic        wr_done_q;

    logic        wt_load;
    logic [15:0] wt_value;
    logic        wt_zero;
    logic        rf_zero;

    logic [3:0]  cmd;
    logic [14:0] addr_c;
    logic [5:0]  col_c;
    logic [15:0] wr_data_c;
    logic        req_ready_c;

    logic        in_init;
    logic        accept;
    logic        row_hit;
    logic        rf_expire;
    logic        ref_done;
    state_t      after_rp;

    assign in_init   = (state == INIT_WAIT) || (state == INIT_ZQC);
    assign accept    = (state == IDLE) && !refresh_pending && bus.req_valid;
    assign row_hit   = row_valid && (open_row == bus.req_row);
    assign rf_expire = !in_init && rf_zero;
    assign ref_done  = (state == RFC_WAIT) && wt_zero;
    // A precharge either opens the way for a held request or for a refresh.
    assign after_rp  = req_busy ? ACT_ISSUE : REF_ISSUE;

    // Wait timer: loaded on the command cycle; the first INIT_WAIT cycle
    // (mem_reset_n still low) loads the power-up NOP count.
    always_comb begin
        wt_load  = 1'b0;
        wt_value = 16'd0;
        case (state)
            INIT_WAIT: begin
                wt_load  = !mem_rst_n_q;
                wt_value = INIT_LOAD;
            end
            PRE_ISSUE: begin
                wt_load  = 1'b1;
                wt_value = RP_LOAD;
            end
            ACT_ISSUE: begin
                wt_load  = 1'b1;
                wt_value = RCD_LOAD;
            end
            REF_ISSUE: begin
                wt_load  = 1'b1;
                wt_value = RFC_LOAD;
            end
            default: ;
        endcase
    end

    ddr3_mem_timer #(.WIDTH(16)) u_wait_timer (
        .clk        (cpu_clk),
        .rst        (cpu_reset),
        .load       (wt_load),
        .load_value (wt_value),
        .en         (1'b1),
        .zero       (wt_zero)
    );

    // Refresh interval: armed on ZQC, then free-running with reload at 0.
    ddr3_mem_timer #(.WIDTH(16)) u_refresh_timer (
        .clk        (cpu_clk),
        .rst        (cpu_reset),
        .load       ((state == INIT_ZQC) || rf_expire),
        .load_value (REFI_LOAD),
        .en         (!in_init),
        .zero       (rf_zero)
    );

    always_ff @(posedge cpu_clk or posedge cpu_reset) begin
        if (cpu_reset) begin
            state <= INIT_WAIT;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            INIT_WAIT: if (mem_rst_n_q && wt_zero) next_state = INIT_ZQC;
            INIT_ZQC:  next_state = IDLE;
            IDLE: begin
                if (refresh_pending) begin
                    next_state = row_valid ? PRE_ISSUE : REF_ISSUE;
                end else if (bus.req_valid) begin
                    if (row_hit)        next_state = CMD_ISSUE;
                    else if (row_valid) next_state = PRE_ISSUE;
                    else                next_state = ACT_ISSUE;
                end
            end
            PRE_ISSUE: next_state = (T_RP > 1) ? RP_WAIT : after_rp;
            RP_WAIT:   if (wt_zero) next_state = after_rp;
            ACT_ISSUE: next_state = RCD_WAIT;
            RCD_WAIT:  if (wt_zero) next_state = CMD_ISSUE;
            CMD_ISSUE: next_state = BURST;
            BURST:     if (beat == 2'd3) next_state = IDLE;
            REF_ISSUE: next_state = RFC_WAIT;
            RFC_WAIT:  if (wt_zero) next_state = IDLE;
            default:   next_state = INIT_WAIT;
        endcase
    end

    always_comb begin
        cmd         = CMD_NOP;
        addr_c      = 15'd0;
        col_c       = 6'd0;
        wr_data_c   = 16'd0;
        req_ready_c = 1'b0;
        case (state)
            INIT_ZQC:  cmd = CMD_ZQC;
            IDLE:      req_ready_c = !refresh_pending;
            PRE_ISSUE: cmd = CMD_PRE;
            ACT_ISSUE: begin
                cmd    = CMD_ACT;
                addr_c = row_q;
            end
            CMD_ISSUE: begin
                cmd    = wr_q ? CMD_WR : CMD_RD;
                addr_c = row_q;
                col_c  = {col_base_q, 2'b00};
            end
            BURST: begin
                addr_c = row_q;
                col_c  = {col_base_q, beat};
                if (wr_q) wr_data_c = wdata_q[{beat, 4'b0000} +: 16];
            end
            REF_ISSUE: cmd = CMD_REF;
            default: ;
        endcase
    end

    always_ff @(posedge cpu_clk or posedge cpu_reset) begin
        if (cpu_reset) begin
            mem_rst_n_q     <= 1'b0;
            wr_q            <= 1'b0;
            row_q           <= 15'd0;
            col_base_q      <= 4'd0;
            wdata_q         <= 64'd0;
            row_valid       <= 1'b0;
            open_row        <= 15'd0;
            refresh_pending <= 1'b0;
            req_busy        <= 1'b0;
            beat            <= 2'd0;
            rd_buf          <= 48'd0;
            rdata_q         <= 64'd0;
            rsp_valid_q     <= 1'b0;
            wr_done_q       <= 1'b0;
        end else begin
            mem_rst_n_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            wr_done_q   <= 1'b0;

            if (accept) begin
                wr_q       <= bus.req_write;
                row_q      <= bus.req_row;
                col_base_q <= bus.req_col[5:2];
                wdata_q    <= bus.req_wdata;
                req_busy   <= 1'b1;
            end

            if (state == PRE_ISSUE) row_valid <= 1'b0;
            if (state == ACT_ISSUE) begin
                row_valid <= 1'b1;
                open_row  <= row_q;
            end
            if (ref_done) row_valid <= 1'b0;

            if (state == CMD_ISSUE) beat <= 2'd0;
            if (state == BURST) begin
                beat <= beat + 2'd1;
                // Beats 0..2 go to a shadow buffer so rsp_rdata only changes
                // when the whole read is complete.
                if (!wr_q) begin
                    case (beat)
                        2'd0:    rd_buf[15:0]  <= bus.rd_data;
                        2'd1:    rd_buf[31:16] <= bus.rd_data;
                        2'd2:    rd_buf[47:32] <= bus.rd_data;
                        default: rdata_q       <= {bus.rd_data, rd_buf};
                    endcase
                end
                if (beat == 2'd3) begin
                    req_busy    <= 1'b0;
                    rsp_valid_q <= !wr_q;
                    wr_done_q   <= wr_q;
                end
            end

            // A new expiry outranks the clear so back-to-back refreshes merge
            // rather than vanish.
            refresh_pending <= rf_expire | (refresh_pending & ~ref_done);
        end
    end

    assign bus.cs_n        = cmd[3];
    assign bus.ras_n       = cmd[2];
    assign bus.cas_n       = cmd[1];
    assign bus.we_n        = cmd[0];
    assign bus.addr        = addr_c;
    assign bus.col         = col_c;
    assign bus.wr_data     = wr_data_c;
    assign bus.req_ready   = req_ready_c;
    assign bus.mem_reset_n = mem_rst_n_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.wr_done     = wr_done_q;
    assign bus.rsp_rdata   = rdata_q;

endmodule

// File: tb/tb_ddr3_mem_scheduler.sv
// tb/tb_ddr3_mem_scheduler.sv - directed self-checking bench for ddr3_mem_scheduler
module tb_ddr3_mem_scheduler;
    import ddr3_mem_pkg::*;

    logic cpu_clk   = 1'b0;
    logic cpu_reset = 1'b1;

    ddr3_mem_scheduler_if bus();

    ddr3_mem_scheduler dut (
        .cpu_clk   (cpu_clk),
        .cpu_reset (cpu_reset),
        .bus       (bus)
    );

    always #5 cpu_clk = ~cpu_clk;

    // Memory model: read data identifies the column it came from.
    assign bus.rd_data = 16'hD000 | {10'd0, bus.col};

    wire [3:0] cmd = {bus.cs_n, bus.ras_n, bus.cas_n, bus.we_n};

    int cyc = 0;
    always @(posedge cpu_clk) cyc++;

    int n_tests = 0;
    int n_fail  = 0;
    int zqc_cyc = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge cpu_clk);
    endtask

    // Entered with cpu_reset high; checks reset outputs, releases, checks init.
    task automatic init_seq(input string name);
        step();
        check({name, " rst cmd"},       cmd,             CMD_NOP);
        check({name, " rst mem_rst_n"}, bus.mem_reset_n, 0);
        check({name, " rst ready"},     bus.req_ready,   0);
        check({name, " rst rsp_valid"}, bus.rsp_valid,   0);
        check({name, " rst wr_done"},   bus.wr_done,     0);
        check({name, " rst rdata"},     bus.rsp_rdata,   0);
        check({name, " rst addr"},      bus.addr,        0);
        check({name, " rst col"},       bus.col,         0);
        check({name, " rst wr_data"},   bus.wr_data,     0);
        cpu_reset = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            step();
            check($sformatf("%s mem_rst_n@%0d", name, k), bus.mem_reset_n, 1);
            check($sformatf("%s cmd@%0d", name, k), cmd, (k == 9) ? CMD_ZQC : CMD_NOP);
            check($sformatf("%s ready@%0d", name, k), bus.req_ready, (k == 10) ? 1 : 0);
            check($sformatf("%s rsp_valid@%0d", name, k), bus.rsp_valid, 0);
            if (k == 9) zqc_cyc = cyc;
        end
    endtask

    // Entered in the IDLE cycle of acceptance (cycle 0). t_pre = 0 means no PRE.
    task automatic txn(input string name, input logic wr, input logic [14:0] row,
                       input logic [5:0] col, input logic [63:0] wdata,
                       input int t_pre, input int t_act, input int t_cmd,
                       input logic [63:0] exp_rdata);
        logic [3:0] exp_cmd;
        int b;
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_row   = row;
        bus.req_col   = col;
        bus.req_wdata = wdata;
        check({name, " ready@0"}, bus.req_ready, 1);
        for (int k = 1; k <= t_cmd + 5; k++) begin
            step();
            if (k == 1) bus.req_valid = 1'b0;
            if (k == t_pre)      exp_cmd = CMD_PRE;
            else if (k == t_act) exp_cmd = CMD_ACT;
            else if (k == t_cmd) exp_cmd = wr ? CMD_WR : CMD_RD;
            else                 exp_cmd = CMD_NOP;
            check($sformatf("%s cmd@%0d", name, k), cmd, exp_cmd);
            if (k == t_act || k == t_cmd)
                check($sformatf("%s addr@%0d", name, k), bus.addr, row);
            if (k > t_cmd && k <= t_cmd + 4) begin
                b = k - t_cmd - 1;
                check($sformatf("%s beat%0d col", name, b), bus.col, {col[5:2], b[1:0]});
                check($sformatf("%s beat%0d addr", name, b), bus.addr, row);
                if (wr) check($sformatf("%s beat%0d wr_data", name, b), bus.wr_data, wdata[b*16 +: 16]);
            end
            check($sformatf("%s rsp_valid@%0d", name, k), bus.rsp_valid, (k == t_cmd + 5 && !wr) ? 1 : 0);
            check($sformatf("%s wr_done@%0d", name, k), bus.wr_done, (k == t_cmd + 5 && wr) ? 1 : 0);
            if (k == t_cmd + 5 && !wr) check({name, " rdata"}, bus.rsp_rdata, exp_rdata);
        end
    endtask

    initial begin
        int rf;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_row   = 15'd0;
        bus.req_col   = 6'd0;
        bus.req_wdata = 64'd0;

        init_seq("init");

        txn("rd_closed", 1'b0, 15'h0123, 6'h08, 64'd0, 0, 1, 3, 64'hD00B_D00A_D009_D008);
        txn("wr_hit", 1'b1, 15'h0123, 6'h3F, 64'h4444_3333_2222_1111, 0, 0, 1, 64'd0);
        check("rdata_hold", bus.rsp_rdata, 64'hD00B_D00A_D009_D008);
        txn("rd_miss", 1'b0, 15'h7FFF, 6'h21, 64'd0, 1, 3, 5, 64'hD023_D022_D021_D020);

        // Refresh becomes pending 781 cycles after the ZQC cycle.
        rf = zqc_cyc + 781;
        for (int i = 0; i < 2000 && cyc < rf - 1; i++) step();
        if (cyc != rf - 1) check("refresh_wait", cyc, rf - 1);
        check("ref ready before expiry", bus.req_ready, 1);
        step();
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_row   = 15'h0200;
        bus.req_col   = 6'h10;
        check("ref ready@0", bus.req_ready, 0);
        for (int k = 1; k <= 13; k++) begin
            step();
            check($sformatf("ref cmd@%0d", k), cmd,
                  (k == 1) ? CMD_PRE : (k == 3) ? CMD_REF : CMD_NOP);
            check($sformatf("ref ready@%0d", k), bus.req_ready, (k == 13) ? 1 : 0);
        end
        txn("rd_after_ref", 1'b0, 15'h0200, 6'h10, 64'd0, 0, 1, 3, 64'hD013_D012_D011_D010);

        // Row hit read, reset asserted in beat 2 (cycle 4).
        bus.req_valid = 1'b1;
        bus.req_row   = 15'h0200;
        bus.req_col   = 6'h10;
        check("rst_burst ready@0", bus.req_ready, 1);
        step();
        bus.req_valid = 1'b0;
        check("rst_burst cmd@1", cmd, CMD_RD);
        step();
        step();
        step();
        check("rst_burst beat2 col", bus.col, 6'h12);
        cpu_reset = 1'b1;
        #1;
        check("rst_burst cmd", cmd, CMD_NOP);
        check("rst_burst mem_rst_n", bus.mem_reset_n, 0);
        check("rst_burst col", bus.col, 0);
        check("rst_burst addr", bus.addr, 0);
        for (int k = 0; k < 2; k++) begin
            step();
            check($sformatf("rst_burst rsp_valid%0d", k), bus.rsp_valid, 0);
        end
        init_seq("reinit");
        txn("rd_after_rst", 1'b0, 15'h0200, 6'h10, 64'd0, 0, 1, 3, 64'hD013_D012_D011_D010);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
